// File: rtl/ram16x4_sync_ctrl.sv
// rtl/ram16x4_sync_ctrl.sv - synchronous request/response front end for the 16x4 async RAM
// Sequences csn/rwn through registered setup/pulse/hold phases so a write never sees a moving address or data.
module ram16x4_sync_ctrl #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 4,
    parameter int WR_PULSE = 2,
    parameter int RD_WAIT  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              wr_done,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_datain,
    output logic              ram_csn,
    output logic              ram_rwn,
    input  logic [DATA_W-1:0] ram_dataout
);

    localparam int CNT_MAX = (WR_PULSE > RD_WAIT + 1) ? WR_PULSE : RD_WAIT + 1;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_PULSE - 1);
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_SETUP,
        S_WR_PULSE,
        S_WR_HOLD,
        S_RD_ACCESS,
        S_RD_RESP
    } state_t;

    state_t              state;
    state_t              state_d;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_d;
    logic                accept;

    logic                csn_d;
    logic                rwn_d;
    logic                wr_done_d;
    logic                rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   datain_d;

    assign req_ready = (state == S_IDLE);
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            ram_csn    <= 1'b1;
            ram_rwn    <= 1'b1;
            ram_addr   <= '0;
            ram_datain <= '0;
            wr_done    <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            ram_csn    <= csn_d;
            ram_rwn    <= rwn_d;
            ram_addr   <= addr_d;
            ram_datain <= datain_d;
            wr_done    <= wr_done_d;
            rsp_valid  <= rsp_valid_d;
            rsp_rdata  <= rsp_rdata_d;
        end
    end

    // The counter is only ever reloaded on entry to a timed phase and counts down to zero.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (req_wr) begin
                        state_d = S_WR_SETUP;
                    end else begin
                        state_d = S_RD_ACCESS;
                        cnt_d   = RD_LOAD;
                    end
                end
            end
            S_WR_SETUP: begin
                state_d = S_WR_PULSE;
                cnt_d   = WR_LOAD;
            end
            S_WR_PULSE: begin
                if (cnt == '0) begin
                    state_d = S_WR_HOLD;
                end else begin
                    cnt_d = cnt - CNT_ONE;
                end
            end
            S_WR_HOLD: begin
                state_d = S_IDLE;
            end
            S_RD_ACCESS: begin
                if (cnt == '0) begin
                    state_d = S_RD_RESP;
                end else begin
                    cnt_d = cnt - CNT_ONE;
                end
            end
            S_RD_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Pin levels are decoded from the state being entered, so they land in flops together with it.
    always_comb begin
        csn_d       = !((state_d == S_WR_PULSE) || (state_d == S_RD_ACCESS));
        rwn_d       = !((state_d == S_WR_SETUP) || (state_d == S_WR_PULSE) || (state_d == S_WR_HOLD));
        wr_done_d   = (state_d == S_WR_HOLD);
        rsp_valid_d = (state_d == S_RD_RESP);
        rsp_rdata_d = rsp_rdata;
        if ((state == S_RD_ACCESS) && (state_d == S_RD_RESP)) begin
            rsp_rdata_d = ram_dataout;
        end
        addr_d   = accept ? req_addr : ram_addr;
        datain_d = (accept && req_wr) ? req_wdata : ram_datain;
    end

endmodule

// File: tb/tb_ram16x4_sync_ctrl.sv
// tb/tb_ram16x4_sync_ctrl.sv - directed bench for ram16x4_sync_ctrl with an async RAM model and read scoreboard
module tb_ram16x4_sync_ctrl;

    localparam int WRP = 2;
    localparam int RDW = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic       req_wr;
    logic [3:0] req_addr;
    logic [3:0] req_wdata;
    logic       wr_done;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_rdata;
    logic [3:0] ram_addr;
    logic [3:0] ram_datain;
    logic       ram_csn;
    logic       ram_rwn;
    logic [3:0] ram_dataout;

    int n_vec = 0;
    int n_err = 0;

    logic [3:0] mem [16];
    logic [3:0] ref_mem [16];
    logic [3:0] exp_q [$];

    always #5 clk = ~clk;

    ram16x4_sync_ctrl #(
        .ADDR_W(4), .DATA_W(4), .WR_PULSE(WRP), .RD_WAIT(RDW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .wr_done(wr_done),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .ram_addr(ram_addr), .ram_datain(ram_datain), .ram_csn(ram_csn),
        .ram_rwn(ram_rwn), .ram_dataout(ram_dataout)
    );

    // Level-sensitive asynchronous RAM.
    always @(ram_csn or ram_rwn or ram_addr or ram_datain) begin
        if (!ram_csn && !ram_rwn) mem[ram_addr] = ram_datain;
    end
    assign ram_dataout = (!ram_csn && ram_rwn) ? mem[ram_addr] : 4'h0;

    logic       prev_low = 1'b0;
    logic [3:0] prev_addr = 4'h0;
    logic [3:0] prev_din = 4'h0;
    always @(negedge clk) begin
        if (!ram_csn && prev_low) begin
            assert (ram_addr === prev_addr && ram_datain === prev_din) else begin
                n_err++;
                $error("FAIL ram_stable: observed addr %0h din %0h expected addr %0h din %0h",
                       ram_addr, ram_datain, prev_addr, prev_din);
            end
        end
        prev_low  = !ram_csn;
        prev_addr = ram_addr;
        prev_din  = ram_datain;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready;
        int n = 0;
        while (!req_ready && n < 50) begin
            tick;
            n++;
        end
        if (!req_ready) check("ready_timeout", 32'(req_ready), 32'd1);
    endtask

    task automatic do_write(input logic [3:0] a, input logic [3:0] d);
        int lo = 0;
        int dn = 0;
        int rdy_at = -1;
        int bad = 0;
        req_valid = 1'b1; req_wr = 1'b1; req_addr = a; req_wdata = d;
        wait_ready;
        tick;
        req_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (!ram_csn) begin
                lo++;
                if (ram_rwn !== 1'b0) bad++;
            end
            if (wr_done) dn++;
            if (ram_addr !== a || ram_datain !== d) bad++;
            if (req_ready) begin
                rdy_at = i;
                break;
            end
            tick;
        end
        check("wr_csn_low_cycles", 32'(lo), 32'(WRP));
        check("wr_done_pulses", 32'(dn), 32'd1);
        check("wr_ready_return", 32'(rdy_at), 32'(2 + WRP));
        check("wr_addr_data_stable", 32'(bad), 32'd0);
        ref_mem[a] = d;
    endtask

    task automatic do_read(input logic [3:0] a, input int hold);
        int lat = -1;
        int bad = 0;
        int hbad = 0;
        logic [3:0] exp_d;
        logic [3:0] d0;
        exp_q.push_back(ref_mem[a]);
        req_valid = 1'b1; req_wr = 1'b0; req_addr = a;
        rsp_ready = (hold == 0);
        wait_ready;
        tick;
        req_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (rsp_valid) begin
                lat = i;
                break;
            end
            if (ram_rwn !== 1'b1 || ram_csn !== 1'b0) bad++;
            tick;
        end
        check("rd_latency", 32'(lat), 32'(RDW + 1));
        check("rd_access_pins", 32'(bad), 32'd0);
        exp_d = exp_q.pop_front();
        check("rd_data", 32'(rsp_rdata), 32'(exp_d));
        d0 = rsp_rdata;
        for (int h = 0; h < hold; h++) begin
            tick;
            if (!rsp_valid || rsp_rdata !== d0 || req_ready || !ram_csn) hbad++;
        end
        if (hold > 0) check("rd_backpressure_hold", 32'(hbad), 32'd0);
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        check("rd_release_ready", 32'(req_ready), 32'd1);
        check("rd_release_valid", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int k;
        int cyc;
        int rsp_n;
        int wd;
        int extra;
        int pend;
        logic [3:0] acc_addr;
        logic [3:0] last_addr;
        logic [3:0] exp_d;

        rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = 4'h0;
        req_wdata = 4'h0; rsp_ready = 1'b0;
        tick;
        tick;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_csn", 32'(ram_csn), 32'd1);
        check("rst_rwn", 32'(ram_rwn), 32'd1);
        check("rst_addr", 32'(ram_addr), 32'd0);
        check("rst_datain", 32'(ram_datain), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_wr_done", 32'(wr_done), 32'd0);
        rst = 1'b0;
        tick;

        do_write(4'd3, 4'hA);
        do_write(4'd7, 4'h5);
        do_read(4'd7, 0);
        do_read(4'd7, 5);

        for (int a = 0; a < 16; a++) do_write(4'(a), 4'(a) ^ 4'hF);
        for (int a = 0; a < 16; a++) do_read(4'(a), 0);

        // Reset in the middle of a write pulse.
        do_write(4'd2, 4'h1);
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 4'd2; req_wdata = 4'hE;
        wait_ready;
        tick;
        req_valid = 1'b0;
        repeat ((WRP > 1) ? 2 : 1) tick;
        check("rst_mid_pre_csn", 32'(ram_csn), 32'd0);
        rst = 1'b1;
        tick;
        check("rst_mid_csn", 32'(ram_csn), 32'd1);
        check("rst_mid_rwn", 32'(ram_rwn), 32'd1);
        check("rst_mid_addr", 32'(ram_addr), 32'd0);
        check("rst_mid_datain", 32'(ram_datain), 32'd0);
        check("rst_mid_wr_done", 32'(wr_done), 32'd0);
        check("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_mid_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_mid_ready", 32'(req_ready), 32'd1);
        rst = 1'b0;
        tick;
        ref_mem[2] = 4'hx;
        do_read(4'd3, 0);

        // Continuous requests alternating write/read.
        k = 0; cyc = 0; rsp_n = 0; wd = 0;
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 4'd4; req_wdata = 4'($urandom);
        last_addr = ram_addr;
        while ((k < 10 || exp_q.size() > 0) && cyc < 500) begin
            pend = 0;
            if (rsp_valid) begin
                if (exp_q.size() > 0) begin
                    exp_d = exp_q.pop_front();
                    check("b2b_rd_data", 32'(rsp_rdata), 32'(exp_d));
                end else begin
                    check("b2b_unexpected_rsp", 32'(rsp_valid), 32'd0);
                end
                rsp_n++;
            end
            if (wr_done) wd++;
            if (k < 10 && req_ready) begin
                if (req_wr) ref_mem[req_addr] = req_wdata;
                else exp_q.push_back(ref_mem[req_addr]);
                pend = 1;
                acc_addr = req_addr;
            end
            tick;
            cyc++;
            if (pend != 0) begin
                check("b2b_accept_addr", 32'(ram_addr), 32'(acc_addr));
                k++;
                if (k < 10) begin
                    req_wr = (k % 2 == 0);
                    req_addr = 4'(k / 2 + 4);
                    req_wdata = 4'($urandom);
                end else begin
                    req_valid = 1'b0;
                end
            end else if (ram_addr !== last_addr) begin
                check("b2b_spurious_accept", 32'(ram_addr), 32'(last_addr));
            end
            last_addr = ram_addr;
        end
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid) extra++;
            if (wr_done) wd++;
            tick;
        end
        check("b2b_accepts", 32'(k), 32'd10);
        check("b2b_responses", 32'(rsp_n), 32'd5);
        check("b2b_writes_done", 32'(wd), 32'd5);
        check("b2b_no_duplicate", 32'(extra), 32'd0);
        rsp_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
